// File: rtl/alu_mul_sequencer_pkg.sv
// Shared types and ALU opcode codes for the shift-add multiply sequencer.
// Imported by the sequencer and by anything that drives the shared ALU.
package alu_mul_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mulseq_state_t;

   // Opcode values as decoded by the shared core ALU
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_NOP = 4'hF;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier that borrows the core's shared ALU.
// It raises alu_req only on steps whose multiplier bit is 1 and stalls until alu_gnt.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] mcand,
   input  logic [WORD_WIDTH-1:0] mplier,
   output logic                  busy,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] prod_hi,
   output logic [WORD_WIDTH-1:0] prod_lo,
   output logic                  alu_req,
   input  logic                  alu_gnt,
   output logic [WORD_WIDTH-1:0] alu_a,
   output logic [WORD_WIDTH-1:0] alu_b,
   output logic                  alu_ic,
   output logic [3:0]            alu_opcode,
   input  logic [WORD_WIDTH-1:0] alu_out,
   input  logic                  alu_cout
);

   localparam int CW = $clog2(WORD_WIDTH + 1);

   mulseq_state_t         state_r;
   logic [WORD_WIDTH-1:0] mcand_r;
   logic [WORD_WIDTH-1:0] acc_hi_r;
   logic [WORD_WIDTH-1:0] acc_lo_r;
   logic [CW-1:0]         cnt_r;
   logic                  busy_r;
   logic                  done_r;
   logic [WORD_WIDTH-1:0] prod_hi_r;
   logic [WORD_WIDTH-1:0] prod_lo_r;
   logic                  alu_req_s;
   logic                  step_s;

   // ALU request and step-commit decode; operands are driven only while requesting
   always_comb begin
      alu_req_s  = 1'b0;
      step_s     = 1'b0;
      alu_a      = {WORD_WIDTH{1'b0}};
      alu_b      = {WORD_WIDTH{1'b0}};
      alu_opcode = OP_NOP;
      if (state_r == RUN) begin
         alu_req_s = acc_lo_r[0];
         step_s    = ~acc_lo_r[0] | alu_gnt;
      end else begin
         alu_req_s = 1'b0;
         step_s    = 1'b0;
      end
      if (alu_req_s) begin
         alu_a      = acc_hi_r;
         alu_b      = mcand_r;
         alu_opcode = OP_ADD;
      end else begin
         alu_a      = {WORD_WIDTH{1'b0}};
         alu_b      = {WORD_WIDTH{1'b0}};
         alu_opcode = OP_NOP;
      end
   end

   // Sequencer FSM with accumulator, step counter and registered status/product
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         mcand_r   <= {WORD_WIDTH{1'b0}};
         acc_hi_r  <= {WORD_WIDTH{1'b0}};
         acc_lo_r  <= {WORD_WIDTH{1'b0}};
         cnt_r     <= {CW{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         prod_hi_r <= {WORD_WIDTH{1'b0}};
         prod_lo_r <= {WORD_WIDTH{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  mcand_r  <= mcand;
                  acc_hi_r <= {WORD_WIDTH{1'b0}};
                  acc_lo_r <= mplier;
                  cnt_r    <= CW'(WORD_WIDTH);
                  busy_r   <= 1'b1;
                  state_r  <= RUN;
               end
            end
            RUN: begin
               // A stalled add step (bit set, no grant) leaves everything untouched
               if (step_s) begin
                  if (acc_lo_r[0]) begin
                     {acc_hi_r, acc_lo_r} <= {alu_cout, alu_out, acc_lo_r[WORD_WIDTH-1:1]};
                  end else begin
                     {acc_hi_r, acc_lo_r} <= {1'b0, acc_hi_r, acc_lo_r[WORD_WIDTH-1:1]};
                  end
                  cnt_r <= cnt_r - CW'(1);
                  if (cnt_r == CW'(1)) begin
                     busy_r  <= 1'b0;
                     state_r <= DONE;
                  end
               end
            end
            DONE: begin
               done_r    <= 1'b1;
               prod_hi_r <= acc_hi_r;
               prod_lo_r <= acc_lo_r;
               state_r   <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign prod_hi = prod_hi_r;
   assign prod_lo = prod_lo_r;
   assign alu_req = alu_req_s;
   assign alu_ic  = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized self-checking bench for alu_mul_sequencer with a behavioural ALU and
// a bit-step/stall reference model derived from the multiply rules.
module tb_alu_mul_sequencer;
   import alu_mul_sequencer_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] mcand;
   logic [W-1:0] mplier;
   logic         busy;
   logic         done;
   logic [W-1:0] prod_hi;
   logic [W-1:0] prod_lo;
   logic         alu_req;
   logic         alu_gnt;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic         alu_ic;
   logic [3:0]   alu_opcode;
   logic [W-1:0] alu_out;
   logic         alu_cout;

   int errors = 0;
   int checks = 0;

   alu_mul_sequencer #(.WORD_WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
      .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
      .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ic(alu_ic), .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_cout(alu_cout)
   );

   always #5 clk = ~clk;

   // Shared ALU: adds only when asked to
   assign {alu_cout, alu_out} = (alu_opcode == OP_ADD) ? ({1'b0, alu_a} + {1'b0, alu_b}) : 33'd0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode: 0 always grant, 1 random grant, 2 deny the first 5 requests
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                          input int abort_step, input int inject_cyc);
      logic [2*W-1:0] exp_p;
      int   i;
      int   cyc;
      int   denied;
      logic need;
      logic g;
      exp_p  = 64'(a) * 64'(b);
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      @(posedge clk); #1;
      start  = 1'b0;
      mcand  = W'($urandom);
      mplier = W'($urandom);
      check_eq("busy_after_start", 64'(busy), 64'd1);
      i = 0; cyc = 0; denied = 0;
      while (i < W && cyc < 4 * W) begin
         if (i == abort_step) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check_eq("abort_busy", 64'(busy), 64'd0);
            check_eq("abort_req", 64'(alu_req), 64'd0);
            check_eq("abort_prod", {prod_hi, prod_lo}, 64'd0);
            check_eq("abort_done", 64'(done), 64'd0);
            for (int k = 0; k < 40; k++) begin
               @(posedge clk); #1;
               check_eq("abort_no_done", 64'(done), 64'd0);
            end
            return;
         end
         need = b[i];
         check_eq("run_req", 64'(alu_req), 64'(need));
         check_eq("run_opcode", 64'(alu_opcode), need ? 64'(OP_ADD) : 64'(OP_NOP));
         check_eq("run_alu_b", 64'(alu_b), need ? 64'(a) : 64'd0);
         check_eq("run_ic", 64'(alu_ic), 64'd0);
         check_eq("run_busy", 64'(busy), 64'd1);
         check_eq("run_done", 64'(done), 64'd0);
         case (mode)
            0:       g = 1'b1;
            1:       g = 1'($urandom_range(0, 1));
            default: g = (denied < 5) ? 1'b0 : 1'b1;
         endcase
         alu_gnt = g;
         if (need && !g) denied++;
         else i++;
         if (cyc == inject_cyc) begin
            start = 1'b1; mcand = 32'd9; mplier = 32'd9;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start   = 1'b0;
      alu_gnt = 1'($urandom_range(0, 1));
      if (i != W) begin
         check_eq("run_timeout", 64'(i), 64'(W));
         return;
      end
      check_eq("donest_done", 64'(done), 64'd0);
      check_eq("donest_busy", 64'(busy), 64'd0);
      check_eq("donest_req", 64'(alu_req), 64'd0);
      @(posedge clk); #1;
      check_eq("done_pulse", 64'(done), 64'd1);
      check_eq("prod", {prod_hi, prod_lo}, exp_p);
      check_eq("done_busy", 64'(busy), 64'd0);
      check_eq("done_opcode", 64'(alu_opcode), 64'(OP_NOP));
   endtask

   task automatic idle_check(input logic [2*W-1:0] exp_p);
      @(posedge clk); #1;
      check_eq("idle_done_low", 64'(done), 64'd0);
      check_eq("idle_prod_held", {prod_hi, prod_lo}, exp_p);
      check_eq("idle_req", 64'(alu_req), 64'd0);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0; alu_gnt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_req", 64'(alu_req), 64'd0);
      check_eq("rst_prod", {prod_hi, prod_lo}, 64'd0);
      check_eq("rst_opcode", 64'(alu_opcode), 64'(OP_NOP));
      check_eq("rst_ab", {alu_a, alu_b}, 64'd0);
      check_eq("rst_ic", 64'(alu_ic), 64'd0);

      run_mul(32'd3, 32'd5, 0, -1, -1);
      idle_check(64'd15);
      run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1, -1);
      idle_check(64'hFFFFFFFE_00000001);
      run_mul(32'h12345678, 32'd0, 1, -1, -1);
      idle_check(64'd0);
      run_mul(32'd7, 32'd3, 2, -1, -1);
      idle_check(64'd21);
      run_mul(32'd2, 32'd4, 0, -1, 5);
      run_mul(32'd9, 32'd9, 0, -1, -1);
      idle_check(64'd81);
      run_mul(W'($urandom), W'($urandom), 0, 10, -1);
      run_mul(32'd6, 32'd7, 0, -1, -1);
      idle_check(64'd42);
      for (int n = 0; n < 8; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (n == 2) rb = rb & 32'h00010001;
         if (n == 3) ra = 32'd0;
         run_mul(ra, rb, 1, -1, -1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
